mem_stage_bus: RTL and testbench

Next-generation MEM pipeline stage for the MIPS core. It sits between the EX/MEM and MEM/WB boundaries and drives an external data-memory bus with a req/ack handshake, so memory latency is variable. It supports byte, halfword and word loads/stores with byte enables and sign/zero extension. It detects misaligned accesses and bus timeouts, stalls upstream while an access is outstanding, and emits a one-cycle result pulse toward WB.

---
 rtl/mem_stage_bus.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage_bus.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_bus.sv
// ============================================================================
//  Module   : mem_stage_bus
//  Brief    : MIPS MEM pipeline stage with req/ack data-memory bus, byte /
//             halfword / word access, load extension, misalignment and bus
//             timeout detection, and a one-cycle result pulse toward WB.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_bus #(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  // EX/MEM side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] w_in,
  input  logic              reg_wen_in,
  input  logic              mem_en_in,
  input  logic              mem_wen_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic [31:0]       store_data_in,
  // data-memory bus
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  // MEM/WB side
  output logic              out_valid,
  output logic [31:0]       result_out,
  output logic [REG_AW-1:0] w_out,
  output logic              reg_wen_out,
  output logic              misalign_out,
  output logic              bus_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value at which one more un-acked request cycle means timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    tcnt;

  // Attributes of the outstanding access, captured at accept time.
  logic [REG_AW-1:0]   cap_w;
  logic                cap_reg_wen;
  logic                cap_store;
  logic                cap_unsigned;
  logic [1:0]          cap_size;
  logic [1:0]          cap_off;
  logic [31:0]         cap_addr;

  logic                accept;
  logic                misaligned;
  logic [3:0]          lane_be;
  logic [31:0]         lane_wdata;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_val;
  logic [31:0]         alu_ext;
  logic [1:0]          in_off;
  logic                timeout_hit;

  assign in_ready    = (state == IDLE) && !reset;
  assign accept      = in_valid && in_ready;
  assign alu_ext     = 32'(alu_result_in);
  assign in_off      = alu_result_in[1:0];
  assign timeout_hit = (tcnt == CNT_LAST);

  // Alignment check: reserved size 11 behaves like a word access.
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_off[0];
      default: misaligned = (in_off != 2'b00);
    endcase
  end

  // Byte-enable and lane-replicated store data for the incoming access.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = store_data_in;
    case (mem_size_in)
      2'b00: begin
        lane_be    = 4'b0001 << in_off;
        lane_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        lane_be    = in_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = store_data_in;
      end
    endcase
  end

  // Little-endian lane select plus sign/zero extension of returning load data.
  always_comb begin
    rd_byte  = mem_rdata[7:0];
    rd_half  = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (cap_off)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    case (cap_size)
      2'b00:   load_val = {{24{!cap_unsigned && rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{!cap_unsigned && rd_half[15]}}, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Stage FSM: accepts instructions, runs the bus handshake, emits result pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 4'b0000;
      mem_wdata    <= '0;
      out_valid    <= 1'b0;
      result_out   <= '0;
      w_out        <= '0;
      reg_wen_out  <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      cap_w        <= '0;
      cap_reg_wen  <= 1'b0;
      cap_store    <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= 2'b00;
      cap_off      <= 2'b00;
      cap_addr     <= '0;
    end else begin
      // Result and exception flags are single-cycle pulses.
      out_valid    <= 1'b0;
      reg_wen_out  <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (!mem_en_in) begin
              out_valid   <= 1'b1;
              result_out  <= alu_ext;
              w_out       <= w_in;
              reg_wen_out <= reg_wen_in;
            end else if (misaligned) begin
              // Report the faulting address; never write a register.
              out_valid    <= 1'b1;
              misalign_out <= 1'b1;
              result_out   <= alu_ext;
              w_out        <= w_in;
              reg_wen_out  <= 1'b0;
            end else begin
              state        <= BUSY;
              tcnt         <= '0;
              mem_req      <= 1'b1;
              mem_we       <= mem_wen_in;
              mem_addr     <= {alu_result_in[ADDR_W-1:2], 2'b00};
              mem_be       <= lane_be;
              mem_wdata    <= lane_wdata;
              cap_w        <= w_in;
              cap_reg_wen  <= reg_wen_in;
              cap_store    <= mem_wen_in;
              cap_unsigned <= mem_unsigned_in;
              cap_size     <= mem_size_in;
              cap_off      <= in_off;
              cap_addr     <= alu_ext;
            end
          end
        end

        BUSY: begin
          if (mem_ack) begin
            // Ack wins even on the cycle the timeout would fire.
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            out_valid  <= 1'b1;
            w_out      <= cap_w;
            if (cap_store) begin
              result_out  <= cap_addr;
              reg_wen_out <= 1'b0;
            end else begin
              result_out  <= load_val;
              reg_wen_out <= cap_reg_wen;
            end
          end else if (timeout_hit) begin
            state       <= IDLE;
            tcnt        <= tcnt + 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            out_valid   <= 1'b1;
            bus_err_out <= 1'b1;
            result_out  <= cap_addr;
            w_out       <= cap_w;
            reg_wen_out <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_bus.sv
// ============================================================================
//  Module   : tb_mem_stage_bus
//  Brief    : Self-checking bench for mem_stage_bus with a reference model of
//             lane selection, extension and handshake timing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_bus;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result_in;
  logic [4:0]  w_in;
  logic        reg_wen_in;
  logic        mem_en_in;
  logic        mem_wen_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;
  logic [31:0] store_data_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] result_out;
  logic [4:0]  w_out;
  logic        reg_wen_out;
  logic        misalign_out;
  logic        bus_err_out;

  int total = 0;
  int bad   = 0;

  mem_stage_bus #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .w_in(w_in), .reg_wen_in(reg_wen_in),
    .mem_en_in(mem_en_in), .mem_wen_in(mem_wen_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .store_data_in(store_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .result_out(result_out), .w_out(w_out),
    .reg_wen_out(reg_wen_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  // Reference model: loaded value from the word, byte offset and size rules.
  function automatic logic [31:0] exp_load(logic [1:0] size, logic uns, logic [1:0] off, logic [31:0] rd);
    int unsigned v;
    if (size == 2'd0) begin
      v = (rd >> (8 * off)) & 32'd255;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (off >= 2) ? (rd >> 16) : (rd & 32'd65535);
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(logic [1:0] size, logic [1:0] off);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] size, logic [31:0] sd);
    if (size == 2'd0) return (sd & 32'd255) * 32'h01010101;
    if (size == 2'd1) return (sd & 32'd65535) * 32'h00010001;
    return sd;
  endfunction

  // Issue one instruction and follow it to its result pulse; ack_dly >= TO means no ack.
  task automatic do_op(input string nm, input logic men, input logic wen, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] w, input logic rwen, input int ack_dly, input logic [31:0] rdata);
    logic mis;
    logic acked;
    logic [31:0] exp_res;
    logic exp_rw;
    mis = men && ((size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0));
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle got=%b exp=1", nm, in_ready); end
    in_valid = 1'b1; alu_result_in = addr; w_in = w; reg_wen_in = rwen; mem_en_in = men;
    mem_wen_in = wen; mem_size_in = size; mem_unsigned_in = uns; store_data_in = sd;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_result_in = $urandom; store_data_in = $urandom; w_in = 5'($urandom);
    if (!men || mis) begin
      total++;
      if (mem_req !== 1'b0) begin bad++; $display("FAIL %s no_req got=%b exp=0", nm, mem_req); end
      total++;
      if ({out_valid, misalign_out, bus_err_out, reg_wen_out} !== {1'b1, mis, 1'b0, (!mis && rwen)}) begin
        bad++; $display("FAIL %s flags got=%b%b%b%b exp=%b%b%b%b", nm, out_valid, misalign_out, bus_err_out,
                        reg_wen_out, 1'b1, mis, 1'b0, (!mis && rwen));
      end
      total++;
      if (result_out !== addr || w_out !== w) begin
        bad++; $display("FAIL %s result got=%h/%0d exp=%h/%0d", nm, result_out, w_out, addr, w);
      end
    end else begin
      total++;
      if ({mem_req, mem_we, mem_be} !== {1'b1, wen, exp_be(size, addr[1:0])} || mem_addr !== (addr & ~32'd3)) begin
        bad++; $display("FAIL %s bus got=%b%b%b@%h exp=%b%b%b@%h", nm, mem_req, mem_we, mem_be, mem_addr,
                        1'b1, wen, exp_be(size, addr[1:0]), addr & ~32'd3);
      end
      if (wen) begin
        total++;
        if (mem_wdata !== exp_wdata(size, sd)) begin
          bad++; $display("FAIL %s wdata got=%h exp=%h", nm, mem_wdata, exp_wdata(size, sd));
        end
      end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL %s ready_busy got=%b exp=0", nm, in_ready); end
      acked = 1'b0;
      for (int c = 0; c < TO; c++) begin
        if (c > 0) begin
          total++;
          if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL %s wait%0d got=req%b ov%b exp=req1 ov0", nm, c, mem_req, out_valid);
          end
        end
        if (c == ack_dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
        else mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (c == ack_dly) begin acked = 1'b1; break; end
      end
      exp_rw  = acked && !wen && rwen;
      exp_res = (wen || !acked) ? addr : exp_load(size, uns, addr[1:0], rdata);
      total++;
      if ({out_valid, mem_req, bus_err_out, misalign_out, reg_wen_out} !== {1'b1, 1'b0, !acked, 1'b0, exp_rw}) begin
        bad++; $display("FAIL %s done got=%b%b%b%b%b exp=%b%b%b%b%b", nm, out_valid, mem_req, bus_err_out,
                        misalign_out, reg_wen_out, 1'b1, 1'b0, !acked, 1'b0, exp_rw);
      end
      if (acked) begin
        total++;
        if (result_out !== exp_res || w_out !== w) begin
          bad++; $display("FAIL %s result got=%h/%0d exp=%h/%0d", nm, result_out, w_out, exp_res, w);
        end
      end
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, misalign_out, bus_err_out, mem_req} !== 4'b0000) begin
      bad++; $display("FAIL %s pulse_end got=%b%b%b%b exp=0000", nm, out_valid, misalign_out, bus_err_out, mem_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_be, out_valid, reg_wen_out, misalign_out, bus_err_out, in_ready} !== 11'd0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0", {mem_req, mem_we, mem_be, out_valid, reg_wen_out,
                      misalign_out, bus_err_out, in_ready});
    end
    total++;
    if ({mem_addr, mem_wdata, result_out, w_out} !== 101'd0) begin
      bad++; $display("FAIL reset_data got=%h %h %h %h exp=0", mem_addr, mem_wdata, result_out, w_out);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    do_op("nonmem", 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    do_op("lb",     1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1, 3, 32'h80112233);
    do_op("lhu",    1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd8, 1'b1, 1, 32'hBEEF0000);
    do_op("lh",     1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd9, 1'b1, 0, 32'hBEEF0000);
    do_op("sb",     1'b1, 1'b1, 2'd0, 1'b0, 32'h201, 32'hAABBCCDD, 5'd3, 1'b0, 0, 32'h0);
    do_op("lw_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd4, 1'b1, 0, 32'h0);
    do_op("lh_mis", 1'b1, 1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 5'd4, 1'b1, 0, 32'h0);
    do_op("timeout", 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd6, 1'b1, TO, 32'h0);
    do_op("ack_last", 1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 5'd6, 1'b1, TO - 1, 32'h12345678);
    do_op("sw_rsvd", 1'b1, 1'b1, 2'd3, 1'b0, 32'h408, 32'hCAFEF00D, 5'd1, 1'b1, 2, 32'h0);
  endtask

  // Reset while BUSY abandons the access; the late ack produces nothing.
  task automatic test_reset_mid();
    in_valid = 1'b1; alu_result_in = 32'h500; mem_en_in = 1'b1; mem_wen_in = 1'b0;
    mem_size_in = 2'd2; w_in = 5'd2; reg_wen_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre got=rdy%b req%b exp=rdy0 req1", in_ready, mem_req);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_drop got=req%b ov%b exp=req0 ov0", mem_req, out_valid);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL rst_mid_late%0d got=ov%b req%b rdy%b exp=ov0 req0 rdy1", c, out_valid, mem_req, in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op("rand", ($urandom % 4) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
            ($urandom & 32'h0000FFF0) | 32'($urandom % 4), $urandom, 5'($urandom), 1'($urandom),
            int'($urandom_range(0, TO)), $urandom);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_result_in = '0; w_in = '0; reg_wen_in = 1'b0;
    mem_en_in = 1'b0; mem_wen_in = 1'b0; mem_size_in = 2'd0; mem_unsigned_in = 1'b0;
    store_data_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
